// File: rtl/trap_csr_if.sv
// Bundles the trap report, CSR access port, interrupt inputs and the CSR/trap status
// outputs of trap_csr_unit. master drives the requests, slave is the CSR block.
interface trap_csr_if;
    logic        exception;
    logic [31:0] exception_pc;
    logic [31:0] exception_cause;
    logic        is_interrupt;
    logic        mret;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        inst_retire;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_soft;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] mtvec_base;
    logic [1:0]  mtvec_mode;
    logic [31:0] mepc_out;
    logic        irq_pending;
    logic [31:0] irq_cause;

    modport master (
        output exception, exception_pc, exception_cause, is_interrupt, mret,
               csr_en, csr_op, csr_addr, csr_wdata, inst_retire,
               irq_ext, irq_timer, irq_soft,
        input  csr_rdata, csr_illegal, mtvec_base, mtvec_mode, mepc_out,
               irq_pending, irq_cause
    );

    modport slave (
        input  exception, exception_pc, exception_cause, is_interrupt, mret,
               csr_en, csr_op, csr_addr, csr_wdata, inst_retire,
               irq_ext, irq_timer, irq_soft,
        output csr_rdata, csr_illegal, mtvec_base, mtvec_mode, mepc_out,
               irq_pending, irq_cause
    );
endinterface

// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file and trap state: commits trap reports, handles MRET, serves Zicsr
// accesses, runs mcycle/minstret and synchronises/prioritises machine interrupts.
module trap_csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    trap_csr_if.slave  bus
);
    logic        r_mstatusMie;
    logic        r_mstatusMpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
    logic [SYNC_STAGES-1:0] r_sync;

    logic [31:0] w_mstatus;
    logic [31:0] w_mip;
    logic [31:0] w_active;
    logic [31:0] w_rdata;
    logic [31:0] w_wval;
    logic        w_mapped;
    logic        w_readOnly;
    logic        w_illegal;
    logic        w_csrWrite;
    logic        w_irqPending;
    logic [31:0] w_irqCause;

    // MPP is hardwired to machine mode; only MIE and MPIE hold state.
    assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatusMpie, 3'b0, r_mstatusMie, 3'b0};
    assign w_mip     = {20'b0, r_sync[SYNC_STAGES-1], 3'b0, bus.irq_timer, 3'b0, bus.irq_soft, 3'b0};
    assign w_active  = w_mip & r_mie;

    always_comb begin
        w_rdata    = 32'h0;
        w_mapped   = 1'b1;
        w_readOnly = 1'b0;
        case (bus.csr_addr)
            12'h300: w_rdata = w_mstatus;
            12'h301: w_rdata = 32'h4000_0100;
            12'h304: w_rdata = r_mie;
            12'h305: w_rdata = r_mtvec;
            12'h340: w_rdata = r_mscratch;
            12'h341: w_rdata = r_mepc;
            12'h342: w_rdata = r_mcause;
            12'h343: w_rdata = r_mtval;
            12'h344: w_rdata = w_mip;
            12'hB00: w_rdata = r_mcycle[31:0];
            12'hB80: w_rdata = r_mcycle[63:32];
            12'hB02: w_rdata = r_minstret[31:0];
            12'hB82: w_rdata = r_minstret[63:32];
            12'hC00: begin w_rdata = r_mcycle[31:0];    w_readOnly = 1'b1; end
            12'hC80: begin w_rdata = r_mcycle[63:32];   w_readOnly = 1'b1; end
            12'hC02: begin w_rdata = r_minstret[31:0];  w_readOnly = 1'b1; end
            12'hC82: begin w_rdata = r_minstret[63:32]; w_readOnly = 1'b1; end
            12'hF14: begin w_rdata = HART_ID;           w_readOnly = 1'b1; end
            default: w_mapped = 1'b0;
        endcase
    end

    always_comb begin
        w_wval = w_rdata;
        case (bus.csr_op)
            2'b01:   w_wval = bus.csr_wdata;
            2'b10:   w_wval = w_rdata | bus.csr_wdata;
            2'b11:   w_wval = w_rdata & ~bus.csr_wdata;
            default: w_wval = w_rdata;
        endcase
    end

    assign w_illegal  = bus.csr_en & (~w_mapped | (w_readOnly & (bus.csr_op != 2'b00)));
    // A trap or MRET in the same cycle wins over the CSR instruction's write.
    assign w_csrWrite = bus.csr_en & ~w_illegal & (bus.csr_op != 2'b00) & ~bus.exception & ~bus.mret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatusMie  <= 1'b0;
            r_mstatusMpie <= 1'b0;
            r_mie         <= 32'h0;
            r_mtvec       <= MTVEC_RESET;
            r_mscratch    <= 32'h0;
            r_mepc        <= 32'h0;
            r_mcause      <= 32'h0;
            r_mtval       <= 32'h0;
        end else if (bus.exception) begin
            r_mepc        <= {bus.exception_pc[31:2], 2'b00};
            r_mcause      <= {bus.is_interrupt, bus.exception_cause[30:0]};
            r_mtval       <= 32'h0;
            r_mstatusMpie <= r_mstatusMie;
            r_mstatusMie  <= 1'b0;
        end else if (bus.mret) begin
            r_mstatusMie  <= r_mstatusMpie;
            r_mstatusMpie <= 1'b1;
        end else if (w_csrWrite) begin
            case (bus.csr_addr)
                12'h300: begin
                    r_mstatusMie  <= w_wval[3];
                    r_mstatusMpie <= w_wval[7];
                end
                12'h304: r_mie      <= w_wval & 32'h0000_0888;
                12'h305: r_mtvec    <= {w_wval[31:2], (w_wval[1] ? 2'b00 : w_wval[1:0])};
                12'h340: r_mscratch <= w_wval;
                12'h341: r_mepc     <= {w_wval[31:2], 2'b00};
                12'h342: r_mcause   <= w_wval;
                12'h343: r_mtval    <= w_wval;
                default: ;
            endcase
        end
    end

    // Writing a counter half takes the place of that counter's increment for the cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcycle   <= 64'h0;
            r_minstret <= 64'h0;
        end else begin
            if (w_csrWrite && bus.csr_addr == 12'hB00)
                r_mcycle[31:0] <= w_wval;
            else if (w_csrWrite && bus.csr_addr == 12'hB80)
                r_mcycle[63:32] <= w_wval;
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (w_csrWrite && bus.csr_addr == 12'hB02)
                r_minstret[31:0] <= w_wval;
            else if (w_csrWrite && bus.csr_addr == 12'hB82)
                r_minstret[63:32] <= w_wval;
            else if (bus.inst_retire)
                r_minstret <= r_minstret + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sync <= '0;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.irq_ext};
    end

    always_comb begin
        w_irqPending = r_mstatusMie & (|w_active) & ~bus.exception;
        w_irqCause   = 32'h0;
        if (w_irqPending) begin
            if (w_active[11])
                w_irqCause = 32'h8000_000B;
            else if (w_active[3])
                w_irqCause = 32'h8000_0003;
            else
                w_irqCause = 32'h8000_0007;
        end
    end

    assign bus.csr_rdata   = w_rdata;
    assign bus.csr_illegal = w_illegal;
    assign bus.mtvec_base  = {r_mtvec[31:2], 2'b00};
    assign bus.mtvec_mode  = r_mtvec[1:0];
    assign bus.mepc_out    = r_mepc;
    assign bus.irq_pending = w_irqPending;
    assign bus.irq_cause   = w_irqCause;
endmodule

// File: tb/tb_trap_csr_unit.sv
// Scoreboard bench for trap_csr_unit: a reference model queues the expected outputs of
// every cycle, and a negedge monitor compares them against the DUT.
module tb_trap_csr_unit;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0000;
    localparam logic [31:0] HART      = 32'h0000_0005;

    logic clk = 1'b0;
    logic rst = 1'b1;
    trap_csr_if bus();

    trap_csr_unit #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        chkRdata;
        logic        illegal;
        logic [31:0] base;
        logic [1:0]  mode;
        logic [31:0] mepcOut;
        logic        pend;
        logic [31:0] cause;
    } exp_t;

    exp_t expQ[$];
    int checks = 0;
    int errors = 0;

    // Stimulus for the next cycle
    logic        tRst, tExc, tIsInt, tMret, tCsrEn, tRetire, tExt, tTimer, tSoft;
    logic [31:0] tPc, tCause, tWdata;
    logic [1:0]  tOp;
    logic [11:0] tAddr;

    // Reference model state
    logic        mMie, mMpie;
    logic [31:0] mMieReg, mMtvec, mMscratch, mMepc, mMcause, mMtval;
    logic [63:0] mCycle, mInstret;
    logic        extHist[$];

    function automatic void modelReset();
        mMie = 0; mMpie = 0; mMieReg = 0; mMtvec = MTVEC_RST;
        mMscratch = 0; mMepc = 0; mMcause = 0; mMtval = 0;
        mCycle = 0; mInstret = 0;
        extHist = '{1'b0, 1'b0};
    endfunction

    function automatic void modelRead(input logic [11:0] a, input logic [31:0] mip,
                                      output logic [31:0] v, output logic mapped, output logic ro);
        mapped = 1; ro = 0; v = 0;
        case (a)
            12'h300: v = 32'h0000_1800 | (32'(mMpie) << 7) | (32'(mMie) << 3);
            12'h301: v = 32'h4000_0100;
            12'h304: v = mMieReg;
            12'h305: v = mMtvec;
            12'h340: v = mMscratch;
            12'h341: v = mMepc;
            12'h342: v = mMcause;
            12'h343: v = mMtval;
            12'h344: v = mip;
            12'hB00: v = mCycle[31:0];
            12'hB80: v = mCycle[63:32];
            12'hB02: v = mInstret[31:0];
            12'hB82: v = mInstret[63:32];
            12'hC00: begin v = mCycle[31:0];    ro = 1; end
            12'hC80: begin v = mCycle[63:32];   ro = 1; end
            12'hC02: begin v = mInstret[31:0];  ro = 1; end
            12'hC82: begin v = mInstret[63:32]; ro = 1; end
            12'hF14: begin v = HART;            ro = 1; end
            default: mapped = 0;
        endcase
    endfunction

    task automatic applyStimulus();
        exp_t        e;
        logic [31:0] old, wv, mip, act;
        logic [63:0] nCycle, nInstret;
        logic        mapped, ro, ill, doWrite, meip;
        @(posedge clk);
        #1;
        rst                 = tRst;
        bus.exception       = tExc;
        bus.exception_pc    = tPc;
        bus.exception_cause = tCause;
        bus.is_interrupt    = tIsInt;
        bus.mret            = tMret;
        bus.csr_en          = tCsrEn;
        bus.csr_op          = tOp;
        bus.csr_addr        = tAddr;
        bus.csr_wdata       = tWdata;
        bus.inst_retire     = tRetire;
        bus.irq_ext         = tExt;
        bus.irq_timer       = tTimer;
        bus.irq_soft        = tSoft;
        if (tRst) begin
            modelReset();
            e.rdata = 0; e.chkRdata = 0; e.illegal = 0;
            e.base = MTVEC_RST & ~32'h3; e.mode = MTVEC_RST[1:0];
            e.mepcOut = 0; e.pend = 0; e.cause = 0;
            expQ.push_back(e);
            return;
        end
        meip = extHist[0];
        mip  = (32'(meip) << 11) | (32'(tTimer) << 7) | (32'(tSoft) << 3);
        modelRead(tAddr, mip, old, mapped, ro);
        ill = tCsrEn && (!mapped || (ro && tOp != 2'b00));
        act = mip & mMieReg;
        e.pend     = mMie && (act != 0) && !tExc;
        e.cause    = !e.pend ? 32'h0 : act[11] ? 32'h8000_000B : act[3] ? 32'h8000_0003 : 32'h8000_0007;
        e.rdata    = old;
        e.chkRdata = tCsrEn && !ill;
        e.illegal  = ill;
        e.base     = mMtvec & ~32'h3;
        e.mode     = mMtvec[1:0];
        e.mepcOut  = mMepc;
        expQ.push_back(e);

        case (tOp)
            2'b01:   wv = tWdata;
            2'b10:   wv = old | tWdata;
            2'b11:   wv = old & ~tWdata;
            default: wv = old;
        endcase
        doWrite  = tCsrEn && !ill && tOp != 2'b00 && !tExc && !tMret;
        nCycle   = mCycle + 64'd1;
        nInstret = tRetire ? mInstret + 64'd1 : mInstret;
        if (tExc) begin
            mMepc   = tPc & ~32'h3;
            mMcause = {tIsInt, tCause[30:0]};
            mMtval  = 0;
            mMpie   = mMie;
            mMie    = 0;
        end else if (tMret) begin
            mMie  = mMpie;
            mMpie = 1;
        end else if (doWrite) begin
            case (tAddr)
                12'h300: begin mMie = wv[3]; mMpie = wv[7]; end
                12'h304: mMieReg = wv & 32'h888;
                12'h305: mMtvec = (wv[1:0] >= 2'd2) ? (wv & ~32'h3) : wv;
                12'h340: mMscratch = wv;
                12'h341: mMepc = wv & ~32'h3;
                12'h342: mMcause = wv;
                12'h343: mMtval = wv;
                12'hB00: nCycle = {mCycle[63:32], wv};
                12'hB80: nCycle = {wv, mCycle[31:0]};
                12'hB02: nInstret = {mInstret[63:32], wv};
                12'hB82: nInstret = {wv, mInstret[31:0]};
                default: ;
            endcase
        end
        mCycle   = nCycle;
        mInstret = nInstret;
        extHist.push_back(tExt);
        void'(extHist.pop_front());
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        e = expQ.pop_front();
        if (e.chkRdata) cmp("csr_rdata", bus.csr_rdata, e.rdata);
        cmp("csr_illegal", 32'(bus.csr_illegal), 32'(e.illegal));
        cmp("mtvec_base", bus.mtvec_base, e.base);
        cmp("mtvec_mode", 32'(bus.mtvec_mode), 32'(e.mode));
        cmp("mepc_out", bus.mepc_out, e.mepcOut);
        cmp("irq_pending", 32'(bus.irq_pending), 32'(e.pend));
        cmp("irq_cause", bus.irq_cause, e.cause);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput();
        end
    end

    task automatic clearStim();
        tRst = 0; tExc = 0; tIsInt = 0; tMret = 0; tCsrEn = 0; tRetire = 0;
        tExt = 0; tTimer = 0; tSoft = 0; tPc = 0; tCause = 0; tWdata = 0;
        tOp = 2'b00; tAddr = 12'h000;
    endtask

    task automatic doCsr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        tCsrEn = 1; tOp = op; tAddr = addr; tWdata = wd;
        applyStimulus();
        tCsrEn = 0; tOp = 0; tAddr = 0; tWdata = 0;
    endtask

    task automatic doIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic doReset(input int n);
        tRst = 1;
        doIdle(n);
        tRst = 0;
    endtask

    localparam int NADDR = 20;
    logic [11:0] addrList [NADDR] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                      12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                      12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14,
                                      12'h7C0, 12'h123};

    initial begin
        clearStim();
        tRst = 1;
        rst = 1;
        bus.exception = 0; bus.exception_pc = 0; bus.exception_cause = 0; bus.is_interrupt = 0;
        bus.mret = 0; bus.csr_en = 0; bus.csr_op = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
        bus.inst_retire = 0; bus.irq_ext = 0; bus.irq_timer = 0; bus.irq_soft = 0;
        modelReset();
        doReset(3);
        doCsr(2'b00, 12'hB00, 0);

        // mtvec WARL mode handling
        doCsr(2'b01, 12'h305, 32'h8000_0101);
        doCsr(2'b10, 12'h305, 32'h1);
        doCsr(2'b11, 12'h305, 32'h1);
        doCsr(2'b01, 12'h305, 32'h3);
        doCsr(2'b01, 12'h305, 32'h2);
        doCsr(2'b00, 12'h305, 0);

        // Trap entry and MRET
        doCsr(2'b01, 12'h300, 32'h8);
        tExc = 1; tPc = 32'h0000_1236; tCause = 32'd2;
        applyStimulus();
        tExc = 0; tPc = 0; tCause = 0;
        doCsr(2'b00, 12'h341, 0);
        doCsr(2'b00, 12'h342, 0);
        doCsr(2'b00, 12'h300, 0);
        tMret = 1; applyStimulus(); tMret = 0;
        doCsr(2'b00, 12'h300, 0);

        // Same-cycle collisions
        doCsr(2'b01, 12'h340, 32'h77);
        tExc = 1; tPc = 32'h0000_2000; tCause = 32'd5;
        doCsr(2'b01, 12'h340, 32'h5);
        tMret = 1; tPc = 32'h0000_3003; tIsInt = 1; tCause = 32'hFFFF_FFF7;
        applyStimulus();
        clearStim();
        doCsr(2'b00, 12'h340, 0);
        doCsr(2'b00, 12'h342, 0);
        doCsr(2'b00, 12'h300, 0);

        // Interrupt synchronisation and priority
        doCsr(2'b01, 12'h304, 32'hFFFF_FFFF);
        doCsr(2'b01, 12'h300, 32'h8);
        tExt = 1; applyStimulus(); tExt = 0;
        doIdle(4);
        tSoft = 1; tTimer = 1; doIdle(2);
        tSoft = 0; doIdle(2);
        tExc = 1; applyStimulus(); tExc = 0;
        tTimer = 0;
        doCsr(2'b01, 12'h344, 32'hFFFF_FFFF);

        // Counter carries and wrap
        doCsr(2'b01, 12'hB80, 32'h0);
        doCsr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        doCsr(2'b00, 12'hB80, 0);
        doCsr(2'b00, 12'hC80, 0);
        doCsr(2'b01, 12'hB80, 32'hFFFF_FFFF);
        doCsr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        doCsr(2'b00, 12'hC00, 0);
        doCsr(2'b00, 12'hC80, 0);
        tRetire = 1; doIdle(3); tRetire = 0;
        doCsr(2'b00, 12'hC02, 0);

        // Illegal accesses leave state untouched
        doCsr(2'b01, 12'hC00, 32'h1234);
        doCsr(2'b00, 12'h7C0, 0);
        doCsr(2'b10, 12'hF14, 32'h1);
        doCsr(2'b00, 12'hF14, 0);
        doCsr(2'b00, 12'h301, 0);

        // Reset in the middle of activity
        doCsr(2'b01, 12'h305, 32'h4000_0041);
        doReset(2);
        doCsr(2'b00, 12'hB00, 0);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            clearStim();
            tCsrEn  = ($urandom_range(0, 1) == 1);
            tAddr   = addrList[$urandom_range(0, NADDR - 1)];
            tOp     = 2'($urandom_range(0, 3));
            tWdata  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            tExc    = ($urandom_range(0, 9) == 0);
            tMret   = !tCsrEn && ($urandom_range(0, 7) == 0);
            tPc     = $urandom;
            tCause  = 32'($urandom_range(0, 15));
            tIsInt  = ($urandom_range(0, 3) == 0);
            tRetire = ($urandom_range(0, 1) == 1);
            tExt    = ($urandom_range(0, 3) == 0);
            tTimer  = ($urandom_range(0, 3) == 0);
            tSoft   = ($urandom_range(0, 3) == 0);
            tRst    = ($urandom_range(0, 199) == 0);
            if (tRst) tCsrEn = 0;
            applyStimulus();
        end
        clearStim();
        doIdle(2);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
